// File: rtl/cpu_pkg.sv
// Shared mini_cpu definitions: bus widths, memory-arbiter state and owner encodings.
package cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } owner_e;

    // Only meaningful when at least one request is high.
    function automatic owner_e pick_owner(logic if_req, logic dm_req, owner_e last);
        if (if_req && dm_req) begin
            return (last == OwnIf) ? OwnDm : OwnIf;
        end
        return if_req ? OwnIf : OwnDm;
    endfunction

endpackage

// File: rtl/cpu_mem_arb_stats.sv
// Saturating grant/conflict counters for the memory arbiter (built only with MEM_ARB_STATS_EN).
module cpu_mem_arb_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_gnt,
    input  logic        dm_gnt,
    input  logic        conflict,
    output logic [15:0] if_gnt_cnt,
    output logic [15:0] dm_gnt_cnt,
    output logic [15:0] conflict_cnt
);

    function automatic logic [15:0] sat_inc(logic [15:0] v, logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt_cnt   <= '0;
            dm_gnt_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if_gnt_cnt   <= sat_inc(if_gnt_cnt, if_gnt);
            dm_gnt_cnt   <= sat_inc(dm_gnt_cnt, dm_gnt);
            conflict_cnt <= sat_inc(conflict_cnt, conflict);
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing cpu_memory between instruction fetch and data access.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module cpu_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW      = ADDR_W,
    parameter int unsigned DW      = DATA_W,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic          IF_RVALID,
    output logic [DW-1:0] IF_RDATA,
    input  logic          DM_REQ,
    input  logic          DM_WE,
    input  logic [AW-1:0] DM_ADDR,
    input  logic [DW-1:0] DM_WDATA,
    output logic          DM_GNT,
    output logic          DM_RVALID,
    output logic [DW-1:0] DM_RDATA,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WE,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]   IF_GNT_CNT,
    output logic [15:0]   DM_GNT_CNT,
    output logic [15:0]   CONFLICT_CNT,
`endif
    input  logic [DW-1:0] MEM_RDATA
);

    localparam int unsigned CntW = 4;

    arb_state_e     state_q;
    owner_e         owner_q;  // doubles as last_owner for the round-robin decision
    owner_e         next_owner;
    logic           we_q;
    logic [CntW-1:0] cnt_q;

    assign next_owner = pick_owner(IF_REQ, DM_REQ, owner_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            owner_q   <= OwnDm;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            IF_GNT    <= 1'b0;
            DM_GNT    <= 1'b0;
            IF_RVALID <= 1'b0;
            DM_RVALID <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            IF_RDATA  <= '0;
            DM_RDATA  <= '0;
        end else begin
            IF_GNT    <= 1'b0;
            DM_GNT    <= 1'b0;
            IF_RVALID <= 1'b0;
            DM_RVALID <= 1'b0;
            MEM_WE    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (IF_REQ || DM_REQ) begin
                        owner_q <= next_owner;
                        cnt_q   <= CntW'(MEM_LAT - 1);
                        state_q <= StAccess;
                        if (next_owner == OwnIf) begin
                            MEM_ADDR <= IF_ADDR;
                            we_q     <= 1'b0;
                            IF_GNT   <= 1'b1;
                        end else begin
                            MEM_ADDR  <= DM_ADDR;
                            MEM_WDATA <= DM_WDATA;
                            we_q      <= DM_WE;
                            DM_GNT    <= 1'b1;
                            // With a single access cycle the strobe starts right away.
                            MEM_WE    <= DM_WE && (MEM_LAT == 1);
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        state_q <= StResp;
                        if (owner_q == OwnIf) begin
                            IF_RDATA  <= MEM_RDATA;
                            IF_RVALID <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                DM_RDATA <= MEM_RDATA;
                            end
                            DM_RVALID <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        MEM_WE <= we_q && (cnt_q == CntW'(1));
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic idle_req;
    assign idle_req = (state_q == StIdle) && (IF_REQ || DM_REQ);

    cpu_mem_arb_stats u_stats (
        .clk          (CLK),
        .rst_n        (RST_N),
        .if_gnt       (idle_req && (next_owner == OwnIf)),
        .dm_gnt       (idle_req && (next_owner == OwnDm)),
        .conflict     ((state_q == StIdle) && IF_REQ && DM_REQ),
        .if_gnt_cnt   (IF_GNT_CNT),
        .dm_gnt_cnt   (DM_GNT_CNT),
        .conflict_cnt (CONFLICT_CNT)
    );
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed vector table, corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_cpu_mem_arbiter;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 3;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b1;
    logic          IF_REQ, DM_REQ, DM_WE;
    logic [AW-1:0] IF_ADDR, DM_ADDR;
    logic [DW-1:0] DM_WDATA;
    logic          IF_GNT, IF_RVALID, DM_GNT, DM_RVALID, MEM_WE;
    logic [DW-1:0] IF_RDATA, DM_RDATA, MEM_WDATA, MEM_RDATA;
    logic [AW-1:0] MEM_ADDR;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   IF_GNT_CNT, DM_GNT_CNT, CONFLICT_CNT;
`endif

    logic [DW-1:0] mem       [256];
    logic [DW-1:0] model_mem [256];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            last_own;
    logic [DW-1:0] exp_if_rd, exp_dm_rd;
    int            m_if_cnt, m_dm_cnt, m_conf_cnt;

    typedef struct {
        logic          ir;
        logic          dr;
        logic          we;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;
        int            exp_own;  // 0 = IF, 1 = DM, 2 = nobody
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t          tbl [10];
    int            own_seen;
    logic [DW-1:0] rd_seen;
    logic          r_ir, r_dr, r_we;
    logic [AW-1:0] r_ia, r_da;
    logic [DW-1:0] r_wd;

    always #5 CLK = ~CLK;

    assign MEM_RDATA = mem[MEM_ADDR];

    cpu_mem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .MEM_LAT (LAT)
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IF_REQ    (IF_REQ),
        .IF_ADDR   (IF_ADDR),
        .IF_GNT    (IF_GNT),
        .IF_RVALID (IF_RVALID),
        .IF_RDATA  (IF_RDATA),
        .DM_REQ    (DM_REQ),
        .DM_WE     (DM_WE),
        .DM_ADDR   (DM_ADDR),
        .DM_WDATA  (DM_WDATA),
        .DM_GNT    (DM_GNT),
        .DM_RVALID (DM_RVALID),
        .DM_RDATA  (DM_RDATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_WE    (MEM_WE),
`ifdef MEM_ARB_STATS_EN
        .IF_GNT_CNT   (IF_GNT_CNT),
        .DM_GNT_CNT   (DM_GNT_CNT),
        .CONFLICT_CNT (CONFLICT_CNT),
`endif
        .MEM_RDATA (MEM_RDATA)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; advances to the next falling edge, acting as cpu_memory.
    task automatic tick();
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #4;
        w = MEM_WE;
        a = MEM_ADDR;
        d = MEM_WDATA;
        @(posedge CLK);
        if (w) mem[a] = d;
        @(negedge CLK);
    endtask

    // One arbitration opportunity, starting at the falling edge of an idle cycle.
    // mode: 0 = hold inputs, 1 = scramble inputs after sampling, 2 = pulse IF_REQ once.
    task automatic run_txn(input logic ir, input logic dr, input logic we,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [DW-1:0] wd, input int mode,
                           output int own_o, output logic [DW-1:0] rd_o);
        int            own;
        logic [AW-1:0] addr;
        logic          st;
        logic [4:0]    exp_s;
        IF_REQ   = ir;
        DM_REQ   = dr;
        DM_WE    = we;
        IF_ADDR  = ia;
        DM_ADDR  = da;
        DM_WDATA = wd;
        own_o    = 2;
        rd_o     = '0;
        if (!ir && !dr) begin
            tick();
            check("idle_no_grant", 32'({IF_GNT, DM_GNT, IF_RVALID, DM_RVALID, MEM_WE}), 32'd0);
            return;
        end
        own = (ir && dr) ? ((last_own == 0) ? 1 : 0) : (ir ? 0 : 1);
        if (ir && dr) m_conf_cnt++;
        if (own == 0) m_if_cnt++;
        else          m_dm_cnt++;
        last_own = own;
        addr     = (own == 1) ? da : ia;
        st       = (own == 1) && we;
        tick();
        for (int c = 1; c <= int'(LAT) + 1; c++) begin
            if (c == int'(LAT) + 1) begin
                if (own == 0)  exp_if_rd = model_mem[addr];
                else if (st)   model_mem[addr] = wd;
                else           exp_dm_rd = model_mem[addr];
            end
            exp_s = {(c == 1) && (own == 0), (c == 1) && (own == 1),
                     (c == int'(LAT) + 1) && (own == 0), (c == int'(LAT) + 1) && (own == 1),
                     st && (c == int'(LAT))};
            if (c == 1) own_o = IF_GNT ? 0 : (DM_GNT ? 1 : 3);
            check("gnt_rvalid_we", 32'({IF_GNT, DM_GNT, IF_RVALID, DM_RVALID, MEM_WE}),
                  32'(exp_s));
            if (c <= int'(LAT)) check("mem_addr", 32'(MEM_ADDR), 32'(addr));
            if (st && (c == int'(LAT))) check("mem_wdata", 32'(MEM_WDATA), 32'(wd));
            check("if_rdata", 32'(IF_RDATA), 32'(exp_if_rd));
            check("dm_rdata", 32'(DM_RDATA), 32'(exp_dm_rd));
            if (mode == 1) begin
                IF_REQ   = 1'($urandom_range(0, 1));
                DM_REQ   = 1'($urandom_range(0, 1));
                DM_WE    = 1'($urandom_range(0, 1));
                IF_ADDR  = 8'($urandom);
                DM_ADDR  = 8'($urandom);
                DM_WDATA = 16'($urandom);
            end else if (mode == 2) begin
                IF_REQ = (c == 1);
            end
            tick();
        end
        rd_o = (own == 0) ? IF_RDATA : DM_RDATA;
    endtask

    task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
        check("if_gnt_cnt", 32'(IF_GNT_CNT), 32'(m_if_cnt));
        check("dm_gnt_cnt", 32'(DM_GNT_CNT), 32'(m_dm_cnt));
        check("conflict_cnt", 32'(CONFLICT_CNT), 32'(m_conf_cnt));
`endif
    endtask

    initial begin
        IF_REQ   = 1'b0;
        DM_REQ   = 1'b0;
        DM_WE    = 1'b0;
        IF_ADDR  = '0;
        DM_ADDR  = '0;
        DM_WDATA = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 16'($urandom);
            model_mem[i] = mem[i];
        end
        mem[8'h10] = 16'hA5A5;  model_mem[8'h10] = 16'hA5A5;
        mem[8'h30] = 16'hBEEF;  model_mem[8'h30] = 16'hBEEF;
        last_own   = 1;
        exp_if_rd  = '0;
        exp_dm_rd  = '0;
        m_if_cnt   = 0;
        m_dm_cnt   = 0;
        m_conf_cnt = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 16'h0000, 0, 16'hA5A5};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 16'h1234, 1, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 16'h0000, 1, 16'h1234};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h10, 16'h0000, 0, 16'hBEEF};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h10, 16'h0000, 1, 16'hA5A5};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h10, 16'h0000, 0, 16'hBEEF};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h10, 16'h0000, 1, 16'hA5A5};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h30, 8'h10, 16'h0000, 2, 16'h0000};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h30, 16'h5555, 1, 16'hA5A5};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h30, 16'h0000, 0, 16'h5555};

        #2 RST_N = 1'b0;
        #1;
        check("reset_strobes", 32'({IF_GNT, DM_GNT, IF_RVALID, DM_RVALID, MEM_WE}), 32'd0);
        check("reset_mem_bus", 32'({MEM_ADDR, MEM_WDATA}), 32'd0);
        check("reset_rdata", {IF_RDATA, DM_RDATA}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        check_stats();

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].ia, tbl[i].da, tbl[i].wd, 0,
                    own_seen, rd_seen);
            check("tbl_owner", 32'(own_seen), 32'(tbl[i].exp_own));
            if (tbl[i].exp_own != 2) check("tbl_rdata", 32'(rd_seen), 32'(tbl[i].exp_rd));
        end
        check_stats();

        // IF_REQ pulses while DM owns the port, then drops: it must never be served.
        run_txn(1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 16'h0000, 2, own_seen, rd_seen);
        check("withdraw_owner", 32'(own_seen), 32'd1);
        run_txn(1'b0, 1'b0, 1'b0, 8'h10, 8'h10, 16'h0000, 0, own_seen, rd_seen);

        // Reset asserted in the strobe cycle of a store.
        IF_REQ   = 1'b0;
        DM_REQ   = 1'b1;
        DM_WE    = 1'b1;
        DM_ADDR  = 8'h40;
        DM_WDATA = 16'h7777;
        repeat (LAT) tick();
        check("pre_reset_we", 32'(MEM_WE), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        check("midrst_strobes", 32'({IF_GNT, DM_GNT, IF_RVALID, DM_RVALID, MEM_WE}), 32'd0);
        check("midrst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("midrst_rdata", {IF_RDATA, DM_RDATA}, 32'd0);
        DM_REQ = 1'b0;
        DM_WE  = 1'b0;
        exp_if_rd  = '0;
        exp_dm_rd  = '0;
        last_own   = 1;
        m_if_cnt   = 0;
        m_dm_cnt   = 0;
        m_conf_cnt = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        run_txn(1'b1, 1'b1, 1'b0, 8'h30, 8'h40, 16'h0000, 0, own_seen, rd_seen);
        check("post_reset_owner", 32'(own_seen), 32'd0);
        run_txn(1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 16'h0000, 0, own_seen, rd_seen);
        check("aborted_store_lost", 32'(rd_seen), 32'(model_mem[8'h40]));
        check_stats();

        for (int k = 0; k < 300; k++) begin
            r_ir = ($urandom_range(0, 4) < 3);
            r_dr = ($urandom_range(0, 4) < 3);
            r_we = 1'($urandom_range(0, 1));
            r_ia = 8'h40 + 8'($urandom_range(0, 7));
            r_da = 8'h40 + 8'($urandom_range(0, 7));
            r_wd = 16'($urandom);
            run_txn(r_ir, r_dr, r_we, r_ia, r_da, r_wd, 1, own_seen, rd_seen);
        end
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
